div_result_display: RTL and testbench
=====================================

DIV_RESULT_DISPLAY -- requirements
Module: div_result_display

Interface
REQ-001 SHALL have parameter: SCAN_DIV, 50000, clock cycles per display digit slot; legal range >=2.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: load  input  1  capture strobe from the divider stage.
REQ-005 SHALL have port: quotient_in  input  4  unsigned quotient from the divider.
REQ-006 SHALL have port: remainder_in  input  4  unsigned remainder from the divider.
REQ-007 SHALL have port: divisor_in  input  4  divisor presented to the divider; used for zero detection only.
REQ-008 SHALL have port: ready  output  1  high when a load is accepted.
REQ-009 SHALL have port: valid  output  1  high once the display holds a converted result.
REQ-010 SHALL have port: err  output  1  divide-by-zero flag.
REQ-011 SHALL have port: seg  output  7  {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port: dp  output  1  decimal point, active-low.
REQ-013 SHALL have port: an  output  4  digit enables, one-hot active-low; an[3] is the leftmost digit.

Function
REQ-014 SHALL use FSM states IDLE, CONV, LATCH; ready = (state==IDLE).
REQ-015 load high in IDLE SHALL capture quotient_in, remainder_in and divisor_in and enter CONV; load outside IDLE SHALL be ignored, with no queuing.
REQ-016 CONV SHALL run double-dabble binary-to-BCD on both operands in parallel, one shift per cycle, for exactly 4 cycles, then enter LATCH.
REQ-017 LATCH SHALL write the display registers, set valid=1 and return to IDLE.
REQ-018 Latency: load accepted at edge N -> ready low for edges N+1..N+5; new digits visible after edge N+5.
REQ-019 Digit mapping: d3=quotient tens, d2=quotient ones, d1=remainder tens, d0=remainder ones.
REQ-020 A tens digit equal to 0 SHALL be blanked; a ones digit SHALL always be shown, including 0.
REQ-021 dp SHALL be low only while d2 is enabled and valid=1.
REQ-022 Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, E=0000110, r=0101111.
REQ-023 Prescaler SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-024 an SHALL be the active-low one-hot of the digit index; scanning SHALL run continuously, independent of FSM state.
REQ-025 While valid=0, seg SHALL be 1111111 and dp=1.
REQ-026 Display registers SHALL keep the previous result during CONV and LATCH, with no partial update.
REQ-027 Boundary: q=15, r=15 SHALL display "1515"; q=0, r=0 SHALL display " 0 0".

Reset
REQ-028 rst_n low SHALL immediately force: state=IDLE, ready=1, valid=0, err=0, prescaler=0, digit index=0, an=1110, seg=1111111, dp=1.
REQ-029 Reset mid-CONV or mid-LATCH SHALL abort the conversion and discard the captured operands.

Configuration
REQ-030 With macro DIV_ZERO_DETECT_EN defined, a load captured with divisor_in==0 SHALL, at LATCH, set err=1 and display d3..d0 = E, r, r, blank, with dp off.
REQ-031 With DIV_ZERO_DETECT_EN defined, the next accepted load with a nonzero divisor SHALL clear err at its LATCH.
REQ-032 Without DIV_ZERO_DETECT_EN, divisor_in SHALL be ignored, err SHALL be tied 0, and results SHALL always display numerically.

Verification
REQ-033 Reset: rst_n low -> ready=1, valid=0, err=0, an=1110, seg=1111111, dp=1.
REQ-034 Basic load: SCAN_DIV=4, load q=13, r=2, divisor=3 -> ready low 5 cycles, then valid=1; slots show d3=1111001, d2=0110000 with dp=0, d1=blank, d0=0100100.
REQ-035 Busy load: second load with q=7 issued 2 cycles after the first -> ignored; display stays "13 2".
REQ-036 Scan: SCAN_DIV=4 -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110.
REQ-037 Divide-by-zero: divisor=0 load -> with DIV_ZERO_DETECT_EN, err=1 and display "Err "; without it, err=0; a following load with q=5, r=1, divisor=2 clears err and shows " 5 1".
REQ-038 Reset mid-operation: rst_n pulsed low on the 2nd CONV cycle -> IDLE, valid=0, blank display, ready=1.

Source files
------------

// File: rtl/div_result_display.sv
// Divider result display: converts a 4-bit quotient and remainder to BCD and
// scans them onto a 4-digit 7-segment display. Optional macro: DIV_ZERO_DETECT_EN.
module div_result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] quotient_in,
    input  logic [3:0] remainder_in,
    input  logic [3:0] divisor_in,
    output logic       ready,
    output logic       valid,
    output logic       err,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    // Handshake: a load is accepted only on a cycle where ready is high;
    // loads presented while ready is low are dropped, never queued.
    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t      state, state_nx;
    logic [11:0] q_sr, r_sr;          // {tens, ones, binary} shift registers
    logic [1:0]  step_cnt;
    logic [3:0]  q_t, q_o, r_t, r_o;
    logic [PW-1:0] presc;
    logic [1:0]  sel;

    function automatic logic [11:0] dd_step(input logic [11:0] v);
        logic [11:0] t;
        t = v;
        if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
        if (t[7:4]  >= 4'd5) t[7:4]  = t[7:4]  + 4'd3;
        return t << 1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = CONV;
            CONV:    if (step_cnt == 2'd3) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sr     <= '0;
            r_sr     <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    step_cnt <= '0;
                    if (load) begin
                        q_sr <= {8'd0, quotient_in};
                        r_sr <= {8'd0, remainder_in};
                    end
                end
                CONV: begin
                    q_sr     <= dd_step(q_sr);
                    r_sr     <= dd_step(r_sr);
                    step_cnt <= step_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Display registers change only in LATCH, so a conversion in flight never shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q_t   <= '0;
            q_o   <= '0;
            r_t   <= '0;
            r_o   <= '0;
        end else if (state == LATCH) begin
            valid <= 1'b1;
            q_t   <= q_sr[11:8];
            q_o   <= q_sr[7:4];
            r_t   <= r_sr[11:8];
            r_o   <= r_sr[7:4];
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic div_zero;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_zero <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE && load) div_zero <= (divisor_in == 4'd0);
            if (state == LATCH)        err      <= div_zero;
        end
    end
`else
    logic unused_divisor;
    assign unused_divisor = ^divisor_in;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            sel   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            sel   <= sel + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign an = ~(4'b0001 << sel);

    always_comb begin
        seg = SEG_BLANK;
        dp  = 1'b1;
        if (valid) begin
            if (err) begin
                case (sel)
                    2'd3:    seg = SEG_E;
                    2'd2:    seg = SEG_R;
                    2'd1:    seg = SEG_R;
                    default: seg = SEG_BLANK;
                endcase
            end else begin
                case (sel)
                    2'd3: seg = (q_t == 4'd0) ? SEG_BLANK : seg7(q_t);
                    2'd2: begin
                        seg = seg7(q_o);
                        dp  = 1'b0;
                    end
                    2'd1: seg = (r_t == 4'd0) ? SEG_BLANK : seg7(r_t);
                    default: seg = seg7(r_o);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_result_display.sv
// Directed bench for div_result_display with SCAN_DIV=4; honours DIV_ZERO_DETECT_EN.
module tb_div_result_display;

    localparam int SCAN_DIV = 4;
    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_3 = 7'b0110000;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_9 = 7'b0010000;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_R = 7'b0101111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] quotient_in, remainder_in, divisor_in;
    logic       ready, valid, err, dp;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    div_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .quotient_in(quotient_in), .remainder_in(remainder_in), .divisor_in(divisor_in),
        .ready(ready), .valid(valid), .err(err),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input int idx, input logic [6:0] exp_seg,
                              input logic exp_dp);
        int n;
        logic [3:0] exp_an;
        n = 0;
        exp_an = ~(4'b0001 << idx);
        while (an !== exp_an && n < 40) begin
            step();
            n++;
        end
        check({tag, "_an"}, 32'(an), 32'(exp_an));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
        check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
    endtask

    task automatic check_disp(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input logic dp2);
        check_slot({tag, "_d3"}, 3, s3, 1'b1);
        check_slot({tag, "_d2"}, 2, s2, dp2);
        check_slot({tag, "_d1"}, 1, s1, 1'b1);
        check_slot({tag, "_d0"}, 0, s0, 1'b1);
    endtask

    task automatic do_load(input string tag, input logic [3:0] q, input logic [3:0] r,
                           input logic [3:0] d);
        quotient_in  = q;
        remainder_in = r;
        divisor_in   = d;
        load = 1'b1;
        step();
        load = 1'b0;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        repeat (5) step();
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        quotient_in = '0;
        remainder_in = '0;
        divisor_in = '0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_an", 32'(an), 32'hE);
        check("rst_seg", 32'(seg), 32'(S_BLANK));
        check("rst_dp", 32'(dp), 32'd1);
        repeat (2) step();
        rst_n = 1'b1;

        // Scan order: each enable held SCAN_DIV cycles, then wraps.
        for (int i = 0; i <= 16; i++) begin
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            check("scan_an", 32'(an), 32'(exp_an));
            if (i < 16) step();
        end

        // Basic load 13 / 2 with a second load attempted while busy.
        quotient_in = 4'd13;
        remainder_in = 4'd2;
        divisor_in = 4'd3;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("basic_ready_low", 32'(ready), 32'd0);
            check("basic_valid_low", 32'(valid), 32'd0);
            if (k == 2) begin
                quotient_in = 4'd7;
                load = 1'b1;
            end
            if (k == 3) load = 1'b0;
            step();
        end
        check("basic_ready", 32'(ready), 32'd1);
        check("basic_valid", 32'(valid), 32'd1);
        check("basic_err", 32'(err), 32'd0);
        check_disp("basic", S_1, S_3, S_BLANK, S_2, 1'b0);

        do_load("max", 4'd15, 4'd15, 4'd1);
        check_disp("max", S_1, S_5, S_1, S_5, 1'b0);

        do_load("zero", 4'd0, 4'd0, 4'd4);
        check_disp("zero", S_BLANK, S_0, S_BLANK, S_0, 1'b0);

        do_load("dz", 4'd9, 4'd0, 4'd0);
`ifdef DIV_ZERO_DETECT_EN
        check("dz_err", 32'(err), 32'd1);
        check_disp("dz", S_E, S_R, S_R, S_BLANK, 1'b1);
`else
        check("dz_err", 32'(err), 32'd0);
        check_disp("dz", S_BLANK, S_9, S_BLANK, S_0, 1'b0);
`endif

        do_load("clr", 4'd5, 4'd1, 4'd2);
        check("clr_err", 32'(err), 32'd0);
        check_disp("clr", S_BLANK, S_5, S_BLANK, S_1, 1'b0);

        // Reset during the second CONV cycle.
        quotient_in = 4'd3;
        remainder_in = 4'd4;
        divisor_in = 4'd1;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_an", 32'(an), 32'hE);
        check("mid_rst_seg", 32'(seg), 32'(S_BLANK));
        check("mid_rst_dp", 32'(dp), 32'd1);
        #2;
        rst_n = 1'b1;
        repeat (8) step();
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_valid", 32'(valid), 32'd0);
        check("post_rst_seg", 32'(seg), 32'(S_BLANK));
        check("post_rst_dp", 32'(dp), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
